bullet_ctrl: RTL and testbench

BULLET_CTRL -- requirements
Module: bullet_ctrl

---
 rtl/bullet_ctrl.sv | 175 +++++++++++++++++
 tb/tb_bullet_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - Tank bullet slots: fire FSM, lowest-free slot allocation and per-frame motion.
module bullet_ctrl #(
    parameter int NUM_BULLETS = 4,
    parameter int LIFETIME    = 300,
    parameter int COOLDOWN    = 8,
    parameter int VEL_SHIFT   = 1
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      ShootBullet,
    input  logic [1:0]                game_end,
    input  logic [9:0]                TankX,
    input  logic [9:0]                TankY,
    input  logic [7:0]                sin,
    input  logic [7:0]                cos,
    input  logic [NUM_BULLETS-1:0]    isWallV,
    input  logic [NUM_BULLETS-1:0]    isWallH,
    input  logic [NUM_BULLETS-1:0]    hit,
    output logic [10*NUM_BULLETS-1:0] BulletX,
    output logic [10*NUM_BULLETS-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]    BulletActive,
    output logic                      Fired
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    // Largest legal positions in 1/8 pixel: 639.875 and 479.875.
    localparam logic signed [14:0] X_MAX = 15'sd5119;
    localparam logic signed [14:0] Y_MAX = 15'sd3839;

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_HOLD, S_COOL} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cool_q, cool_d;
    logic                   fired_q, fired_d;
    logic                   round_over;
    logic [NUM_BULLETS-1:0] free_sel, spawn_sel;
    logic                   free_found;
    logic [6:0]             mag_x, mag_y;
    logic [12:0]            spawn_vx, spawn_vy;

    assign round_over = |game_end;
    assign mag_x      = cos[6:0] >> VEL_SHIFT;
    assign mag_y      = sin[6:0] >> VEL_SHIFT;
    assign spawn_vx   = cos[7] ? -{6'b0, mag_x} : {6'b0, mag_x};
    // Screen Y grows downward, so a positive sine moves the bullet up.
    assign spawn_vy   = sin[7] ? {6'b0, mag_y} : -{6'b0, mag_y};
    assign Fired      = fired_q;

    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!BulletActive[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cool_d    = cool_q;
        fired_d   = 1'b0;
        spawn_sel = '0;
        if (round_over) begin
            state_d = S_HOLD;
            cool_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (ShootBullet) state_d = S_FIRE;
                S_FIRE: begin
                    state_d   = S_HOLD;
                    spawn_sel = free_sel;
                    fired_d   = free_found;
                end
                S_HOLD: if (!ShootBullet) state_d = S_COOL;
                S_COOL: begin
                    if (cool_q == CW'(COOLDOWN - 1)) begin
                        state_d = S_IDLE;
                        cool_d  = '0;
                    end else begin
                        cool_d = cool_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cool_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            fired_q <= fired_d;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        logic [12:0]        px_q, px_d, py_q, py_d;
        logic signed [12:0] vx_q, vx_d, vy_q, vy_d;
        logic signed [12:0] vx_m, vy_m;
        logic signed [14:0] nx, ny;
        logic [8:0]         life_q, life_d;
        logic               act_q, act_d;

        always_comb begin
            px_d   = px_q;
            py_d   = py_q;
            vx_d   = vx_q;
            vy_d   = vy_q;
            life_d = life_q;
            act_d  = act_q;
            vx_m   = isWallV[g] ? -vx_q : vx_q;
            vy_m   = isWallH[g] ? -vy_q : vy_q;
            nx     = $signed({2'b00, px_q}) + $signed({{2{vx_m[12]}}, vx_m});
            ny     = $signed({2'b00, py_q}) + $signed({{2{vy_m[12]}}, vy_m});
            if (round_over) begin
                act_d = 1'b0;
            end else if (spawn_sel[g]) begin
                act_d  = 1'b1;
                px_d   = {TankX, 3'b000};
                py_d   = {TankY, 3'b000};
                vx_d   = spawn_vx;
                vy_d   = spawn_vy;
                life_d = 9'(LIFETIME);
            end else if (act_q) begin
                if (hit[g] || life_q == 9'd0) begin
                    act_d = 1'b0;
                end else begin
                    life_d = life_q - 9'd1;
                    // Off-screen step: bounce by reversing, position held this frame.
                    if (nx[14] || nx > X_MAX) begin
                        vx_d = -vx_m;
                    end else begin
                        vx_d = vx_m;
                        px_d = nx[12:0];
                    end
                    if (ny[14] || ny > Y_MAX) begin
                        vy_d = -vy_m;
                    end else begin
                        vy_d = vy_m;
                        py_d = ny[12:0];
                    end
                end
            end
        end

        always_ff @(posedge frame_clk or negedge Reset_n) begin
            if (!Reset_n) begin
                px_q   <= '0;
                py_q   <= '0;
                vx_q   <= '0;
                vy_q   <= '0;
                life_q <= '0;
                act_q  <= 1'b0;
            end else begin
                px_q   <= px_d;
                py_q   <= py_d;
                vx_q   <= vx_d;
                vy_q   <= vy_d;
                life_q <= life_d;
                act_q  <= act_d;
            end
        end

        assign BulletX[10*g +: 10] = px_q[12:3];
        assign BulletY[10*g +: 10] = py_q[12:3];
        assign BulletActive[g]     = act_q;
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - Scoreboard bench for bullet_ctrl: frame-stamped checks and Fired tracking.
module tb_bullet_ctrl;

    localparam int K_ACT   = 0;
    localparam int K_X     = 1;
    localparam int K_Y     = 2;
    localparam int K_FIRED = 3;

    typedef struct packed {
        int frame;
        int kind;
        int slot;
        int val;
        int tag;
    } chk_t;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic        ShootBullet;
    logic [1:0]  game_end;
    logic [9:0]  TankX, TankY;
    logic [7:0]  sin, cos;
    logic [3:0]  isWallV, isWallH, hit;
    logic [39:0] BulletX, BulletY;
    logic [3:0]  BulletActive;
    logic        Fired;

    chk_t       chk_q[$];
    int         fire_q[$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] prev_act = 4'b0000;

    bullet_ctrl #(
        .NUM_BULLETS(4), .LIFETIME(300), .COOLDOWN(8), .VEL_SHIFT(1)
    ) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .ShootBullet(ShootBullet),
        .game_end(game_end), .TankX(TankX), .TankY(TankY), .sin(sin), .cos(cos),
        .isWallV(isWallV), .isWallH(isWallH), .hit(hit),
        .BulletX(BulletX), .BulletY(BulletY), .BulletActive(BulletActive), .Fired(Fired)
    );

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_ACT:   return "active";
            K_X:     return "pos_x";
            K_Y:     return "pos_y";
            default: return "fired";
        endcase
    endfunction

    task automatic chk(input int frame, input int kind, input int slot, input int val, input int tag);
        chk_t c;
        c.frame = frame;
        c.kind  = kind;
        c.slot  = slot;
        c.val   = val;
        c.tag   = tag;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One press/release: key high for two edges, then released with room for the cooldown.
    task automatic press(input int slot, input int act_exp, input int tag);
        int p;
        p = cyc;
        ShootBullet = 1'b1;
        chk(p + 2, K_FIRED, 0, (slot >= 0) ? 1 : 0, tag);
        chk(p + 2, K_ACT, 0, act_exp, tag);
        if (slot >= 0) begin
            fire_q.push_back(slot);
            chk(p + 2, K_X, slot, 300, tag);
            chk(p + 2, K_Y, slot, 250, tag);
        end
        ticks(2);
        ShootBullet = 1'b0;
        ticks(12);
    endtask

    always @(negedge frame_clk) begin
        logic [3:0] newly, want;
        int         es, got;
        chk_t       c;
        if (Fired) begin
            total++;
            newly = BulletActive & ~prev_act;
            if (fire_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_fire frame=%0d got=fired active=%b want=no_fire", cyc, BulletActive);
            end else begin
                es   = fire_q.pop_front();
                want = 4'b0001 << es;
                if (newly != want) begin
                    bad++;
                    $display("FAIL fire_slot frame=%0d got_new=%b want_new=%b", cyc, newly, want);
                end
            end
        end
        prev_act = BulletActive;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].frame == cyc) begin
                c = chk_q[i];
                case (c.kind)
                    K_ACT:   got = int'(BulletActive);
                    K_X:     got = int'(BulletX[10*c.slot +: 10]);
                    K_Y:     got = int'(BulletY[10*c.slot +: 10]);
                    default: got = int'(Fired);
                endcase
                total++;
                if (got != c.val) begin
                    bad++;
                    $display("FAIL %s tag=%0d frame=%0d slot=%0d got=%0d want=%0d",
                             kname(c.kind), c.tag, c.frame, c.slot, got, c.val);
                end
                chk_q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish frame=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, s2, s3, s, w, k;
        Reset_n     = 1'b0;
        ShootBullet = 1'b0;
        game_end    = 2'b00;
        TankX       = 10'd300;
        TankY       = 10'd250;
        cos         = 8'h40;
        sin         = 8'h00;
        isWallV     = 4'b0000;
        isWallH     = 4'b0000;
        hit         = 4'b0000;

        tick();
        chk(cyc, K_ACT, 0, 0, 1);
        chk(cyc, K_FIRED, 0, 0, 1);
        chk(cyc, K_X, 0, 0, 1);
        chk(cyc, K_Y, 3, 0, 1);
        tick();
        Reset_n = 1'b1;

        // Key held 20 frames: one bullet, +4 px/frame in X.
        tick();
        p = cyc;
        ShootBullet = 1'b1;
        fire_q.push_back(0);
        chk(p + 1, K_ACT, 0, 0, 2);
        chk(p + 2, K_ACT, 0, 1, 2);
        chk(p + 2, K_FIRED, 0, 1, 2);
        chk(p + 2, K_X, 0, 300, 2);
        chk(p + 2, K_Y, 0, 250, 2);
        chk(p + 3, K_FIRED, 0, 0, 2);
        chk(p + 3, K_X, 0, 304, 2);
        chk(p + 7, K_X, 0, 320, 2);
        chk(p + 12, K_X, 0, 340, 2);
        chk(p + 12, K_Y, 0, 250, 2);
        chk(p + 15, K_FIRED, 0, 0, 2);
        chk(p + 20, K_X, 0, 372, 2);
        chk(p + 20, K_ACT, 0, 1, 2);
        ticks(20);

        // Release plus one-frame vertical wall on slot0.
        ShootBullet = 1'b0;
        isWallV     = 4'b0001;
        chk(p + 21, K_X, 0, 368, 3);
        chk(p + 25, K_X, 0, 352, 3);
        tick();
        isWallV = 4'b0000;
        // Key during cooldown must be ignored.
        ShootBullet = 1'b1;
        ticks(3);
        ShootBullet = 1'b0;
        ticks(7);

        // Fill slots 1..3 with different headings.
        s2  = cyc + 2;
        sin = 8'hA0;
        chk(s2 + 2, K_Y, 1, 254, 4);
        press(1, 4'b0011, 4);
        s3  = cyc + 2;
        sin = 8'h40;
        cos = 8'h00;
        chk(s3 + 2, K_Y, 2, 242, 4);
        chk(s3 + 62, K_Y, 2, 2, 7);
        chk(s3 + 63, K_Y, 2, 2, 7);
        chk(s3 + 64, K_Y, 2, 6, 7);
        chk(s3 + 64, K_X, 2, 300, 7);
        press(2, 4'b0111, 4);
        sin = 8'h00;
        cos = 8'hC0;
        chk(cyc + 3, K_X, 3, 296, 4);
        press(3, 4'b1111, 4);

        // Both walls on slot1 for one frame.
        w = cyc;
        k = w - s2;
        isWallV = 4'b0010;
        isWallH = 4'b0010;
        chk(w + 1, K_X, 1, 300 + 4 * k - 4, 3);
        chk(w + 1, K_Y, 1, 250 + 2 * k - 2, 3);
        chk(w + 2, K_X, 1, 300 + 4 * k - 8, 3);
        chk(w + 2, K_Y, 1, 250 + 2 * k - 4, 3);
        tick();
        isWallV = 4'b0000;
        isWallH = 4'b0000;
        ticks(2);

        press(-1, 4'b1111, 4);

        // Hit on slot1 with a new press: freed slot reused one frame later.
        p = cyc;
        ShootBullet = 1'b1;
        hit = 4'b0010;
        fire_q.push_back(1);
        chk(p + 1, K_ACT, 0, 4'b1101, 5);
        chk(p + 2, K_ACT, 0, 4'b1111, 5);
        chk(p + 2, K_FIRED, 0, 1, 5);
        chk(p + 2, K_X, 1, 300, 5);
        tick();
        hit = 4'b0000;
        tick();
        ShootBullet = 1'b0;
        ticks(12);

        // Slot3 freed on the allocation edge itself: nothing spawns.
        p = cyc;
        ShootBullet = 1'b1;
        chk(p + 2, K_ACT, 0, 4'b0111, 6);
        chk(p + 2, K_FIRED, 0, 0, 6);
        chk(p + 3, K_ACT, 0, 4'b0111, 6);
        tick();
        hit = 4'b1000;
        tick();
        hit = 4'b0000;
        ShootBullet = 1'b0;
        ticks(12);
        while (cyc < s3 + 65) tick();

        // Asynchronous reset mid-flight.
        Reset_n = 1'b0;
        chk(cyc, K_ACT, 0, 0, 8);
        chk(cyc, K_FIRED, 0, 0, 8);
        chk(cyc, K_X, 0, 0, 8);
        chk(cyc, K_Y, 2, 0, 8);
        tick();
        Reset_n = 1'b1;

        // Stationary bullet lifetime.
        cos = 8'h00;
        sin = 8'h00;
        s   = cyc + 2;
        chk(s + 150, K_X, 0, 300, 9);
        chk(s + 150, K_Y, 0, 250, 9);
        chk(s + 300, K_ACT, 0, 1, 9);
        chk(s + 301, K_ACT, 0, 0, 9);
        press(0, 4'b0001, 9);
        while (cyc < s + 302) tick();

        // Round over with the key held, then restart without re-press.
        cos = 8'h40;
        p   = cyc;
        ShootBullet = 1'b1;
        fire_q.push_back(0);
        chk(p + 2, K_FIRED, 0, 1, 10);
        chk(p + 2, K_ACT, 0, 1, 10);
        ticks(4);
        game_end = 2'b10;
        chk(p + 5, K_ACT, 0, 0, 10);
        chk(p + 5, K_FIRED, 0, 0, 10);
        ticks(3);
        game_end = 2'b00;
        chk(p + 12, K_FIRED, 0, 0, 10);
        chk(p + 16, K_ACT, 0, 0, 10);
        ticks(10);
        ShootBullet = 1'b0;
        ticks(10);
        press(0, 4'b0001, 10);
        ticks(3);

        foreach (chk_q[i]) begin
            total++;
            bad++;
            $display("FAIL unreached_%s tag=%0d frame=%0d got=none want=%0d",
                     kname(chk_q[i].kind), chk_q[i].tag, chk_q[i].frame, chk_q[i].val);
        end
        while (fire_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing_fire got=none want_slot=%0d", fire_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
